// File: rtl/solver_work_dispatcher_if.sv
// Work-dispatch bus between the dispatcher and the Mandelbrot iteration engines.
// master = dispatcher side, slave = engine array side.
interface solver_work_dispatcher_if #(
  parameter int NUM_SOLVERS = 29,
  parameter int FRAC_W      = 27
);
  logic [NUM_SOLVERS-1:0]   req;
  logic [NUM_SOLVERS-1:0]   complete;
  logic [NUM_SOLVERS-1:0]   grant;
  logic [9:0]               grant_x;
  logic [8:0]               grant_y;
  logic [18:0]              grant_addr;
  logic signed [FRAC_W-1:0] grant_cr;
  logic signed [FRAC_W-1:0] grant_ci;

  modport master (
    input  req, complete,
    output grant, grant_x, grant_y, grant_addr, grant_cr, grant_ci
  );

  modport slave (
    output req, complete,
    input  grant, grant_x, grant_y, grant_addr, grant_cr, grant_ci
  );
endinterface

// File: rtl/solver_work_dispatcher.sv
// Round-robin pixel dispatcher for a Mandelbrot solver array: hands out (x, y, c) per
// grant, counts completions and times the frame.
module solver_work_dispatcher #(
  parameter int NUM_SOLVERS = 29,
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int FRAC_W      = 27
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [FRAC_W-1:0] min_x,
  input  logic signed [FRAC_W-1:0] min_y,
  input  logic signed [FRAC_W-1:0] dx,
  input  logic signed [FRAC_W-1:0] dy,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              solve_time,
  solver_work_dispatcher_if.master bus
);
  localparam int unsigned TOTAL = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int PTR_W = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
  localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StDispatch, StDrain, StDone} state_e;

  state_e                   state_q, state_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [9:0]               x_q, x_d;
  logic [8:0]               y_q, y_d;
  logic [18:0]              addr_q, addr_d;
  logic signed [FRAC_W-1:0] cr_q, cr_d, ci_q, ci_d;
  logic signed [FRAC_W-1:0] minx_q, minx_d, dx_q, dx_d, dy_q, dy_d;
  logic [CNT_W-1:0]         granted_q, granted_d, completed_q, completed_d;
  logic [NUM_SOLVERS-1:0]   grant_q, grant_d;
  logic [9:0]               gx_q, gx_d;
  logic [8:0]               gy_q, gy_d;
  logic [18:0]              gaddr_q, gaddr_d;
  logic signed [FRAC_W-1:0] gcr_q, gcr_d, gci_q, gci_d;
  logic                     busy_q, busy_d, done_q, done_d;
  logic [31:0]              time_q, time_d;

  logic [NUM_SOLVERS-1:0]   eligible;
  logic                     found;
  logic [PTR_W-1:0]         winner;
  int unsigned              idx;
  int unsigned              pop;
  logic [CNT_W-1:0]         outstanding, accept;

  // The engine granted last cycle still shows req while it reacts, so it is masked.
  always_comb begin
    eligible = bus.req & ~grant_q;
    found    = 1'b0;
    winner   = '0;
    idx      = 0;
    for (int i = 0; i < NUM_SOLVERS; i++) begin
      idx = 32'(ptr_q) + 32'(i);
      if (idx >= NUM_SOLVERS) idx = idx - NUM_SOLVERS;
      if (!found && eligible[idx[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    pop = 0;
    for (int i = 0; i < NUM_SOLVERS; i++) pop = pop + 32'(bus.complete[i]);
    outstanding = granted_q - completed_q;
    accept      = (pop > 32'(outstanding)) ? outstanding : CNT_W'(pop);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    cr_d        = cr_q;
    ci_d        = ci_q;
    minx_d      = minx_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    granted_d   = granted_q;
    completed_d = completed_q;
    grant_d     = '0;
    gx_d        = gx_q;
    gy_d        = gy_q;
    gaddr_d     = gaddr_q;
    gcr_d       = gcr_q;
    gci_d       = gci_q;
    busy_d      = busy_q;
    done_d      = done_q;
    time_d      = time_q;

    if (busy_q && time_q != '1) time_d = time_q + 32'd1;
    if (state_q == StDispatch || state_q == StDrain) completed_d = completed_q + accept;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StDispatch;
          minx_d      = min_x;
          dx_d        = dx;
          dy_d        = dy;
          x_d         = '0;
          y_d         = '0;
          addr_d      = '0;
          cr_d        = min_x;
          ci_d        = min_y;
          granted_d   = '0;
          completed_d = '0;
          time_d      = '0;
          done_d      = 1'b0;
          busy_d      = 1'b1;
        end
      end
      StDispatch: begin
        if (found) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          gx_d            = x_q;
          gy_d            = y_q;
          gaddr_d         = addr_q;
          gcr_d           = cr_q;
          gci_d           = ci_q;
          ptr_d           = (winner == PTR_W'(NUM_SOLVERS - 1)) ? '0 : winner + PTR_W'(1);
          granted_d       = granted_q + CNT_W'(1);
          addr_d          = addr_q + 19'd1;
          if (x_q != X_LAST) begin
            x_d  = x_q + 10'd1;
            cr_d = cr_q + dx_q;
          end else begin
            x_d  = '0;
            cr_d = minx_q;
            y_d  = y_q + 9'd1;
            ci_d = ci_q + dy_q;
            if (y_q == Y_LAST) state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (completed_d == CNT_W'(TOTAL)) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      cr_q        <= '0;
      ci_q        <= '0;
      minx_q      <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      granted_q   <= '0;
      completed_q <= '0;
      grant_q     <= '0;
      gx_q        <= '0;
      gy_q        <= '0;
      gaddr_q     <= '0;
      gcr_q       <= '0;
      gci_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      time_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      cr_q        <= cr_d;
      ci_q        <= ci_d;
      minx_q      <= minx_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      granted_q   <= granted_d;
      completed_q <= completed_d;
      grant_q     <= grant_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      gaddr_q     <= gaddr_d;
      gcr_q       <= gcr_d;
      gci_q       <= gci_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      time_q      <= time_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.grant_x    = gx_q;
  assign bus.grant_y    = gy_q;
  assign bus.grant_addr = gaddr_q;
  assign bus.grant_cr   = gcr_q;
  assign bus.grant_ci   = gci_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign solve_time     = time_q;
endmodule

// File: tb/tb_solver_work_dispatcher.sv
// Directed and randomized bench for solver_work_dispatcher against a frame-level
// reference model (pixel index -> coordinates computed by multiplication).
module tb_solver_work_dispatcher;
  localparam int N = 3, W = 4, H = 3, F = 27, TOTAL = W * H;

  logic                clock = 1'b0;
  logic                reset, start;
  logic signed [F-1:0] min_x, min_y, dx, dy;
  logic                busy, done;
  logic [31:0]         solve_time;
  int                  checks = 0, errors = 0;

  solver_work_dispatcher_if #(.NUM_SOLVERS(N), .FRAC_W(F)) bus ();

  solver_work_dispatcher #(.NUM_SOLVERS(N), .WIDTH(W), .HEIGHT(H), .FRAC_W(F)) dut (
    .clock(clock), .reset(reset), .start(start), .min_x(min_x), .min_y(min_y), .dx(dx),
    .dy(dy), .busy(busy), .done(done), .solve_time(solve_time), .bus(bus)
  );

  always #5 clock = ~clock;

  // Reference model state: frame progress as counts, pixel data from the pixel index.
  bit                  m_busy, m_done;
  int                  m_ptr, m_granted, m_completed;
  longint              m_time;
  logic [N-1:0]        e_grant;
  int                  e_x, e_y, e_addr;
  logic signed [F-1:0] e_cr, e_ci;
  longint              l_minx, l_miny, l_dx, l_dy;
  int                  meas;
  logic signed [F-1:0] wrap_exp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int pop, acc, win;
    bit was_drain;
    logic [N-1:0] elig;
    if (reset) begin
      m_busy = 0; m_done = 0; m_ptr = 0; m_granted = 0; m_completed = 0; m_time = 0;
      e_grant = '0; e_x = 0; e_y = 0; e_addr = 0; e_cr = '0; e_ci = '0;
    end else if (start && !m_busy) begin
      l_minx = longint'(min_x); l_miny = longint'(min_y);
      l_dx = longint'(dx); l_dy = longint'(dy);
      m_busy = 1; m_done = 0; m_granted = 0; m_completed = 0; m_time = 0; e_grant = '0;
    end else if (m_busy) begin
      if (m_time < 64'hFFFF_FFFF) m_time++;
      pop = $countones(bus.complete);
      acc = (pop < m_granted - m_completed) ? pop : m_granted - m_completed;
      m_completed += acc;
      was_drain = (m_granted == TOTAL);
      elig = bus.req & ~e_grant;
      win = -1;
      if (!was_drain)
        for (int k = 0; k < N; k++)
          if (win < 0 && elig[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      if (win >= 0) begin
        e_grant = N'(1) << win;
        e_x = m_granted % W; e_y = m_granted / W; e_addr = m_granted;
        e_cr = F'(l_minx + longint'(e_x) * l_dx);
        e_ci = F'(l_miny + longint'(e_y) * l_dy);
        m_granted++;
        m_ptr = (win + 1) % N;
      end else begin
        e_grant = '0;
      end
      if (was_drain && m_completed == TOTAL) begin
        m_busy = 0; m_done = 1;
      end
    end else begin
      e_grant = '0;
    end
  endtask

  task automatic check_all();
    chk("grant", 64'(bus.grant), 64'(e_grant));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("solve_time", 64'(solve_time), 64'(m_time));
    chk("grant_x", 64'(bus.grant_x), 64'(e_x));
    chk("grant_y", 64'(bus.grant_y), 64'(e_y));
    chk("grant_addr", 64'(bus.grant_addr), 64'(e_addr));
    chk("grant_cr", 64'(bus.grant_cr), 64'(e_cr));
    chk("grant_ci", 64'(bus.grant_ci), 64'(e_ci));
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    @(negedge clock);
    if (m_busy) meas++;
    check_all();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bus.req = '0; bus.complete = '0;
    min_x = -27'sd100; min_y = 27'sd50; dx = 27'sd10; dy = -27'sd5;
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_time", 64'(solve_time), 64'd0);
    reset = 1'b0;
    bus.complete = '1; tick(); bus.complete = '0; tick();

    // Frame A: single requester holding req, completions sprinkled in.
    meas = 0; start = 1'b1; tick(); start = 1'b0;
    bus.req = 3'b001;
    for (int c = 0; c < 40 && m_granted < TOTAL; c++) begin
      bus.complete = (c == 1 || c == 6) ? 3'b111 : 3'b000;
      tick();
      if (e_grant != '0 && e_addr == 5) begin
        chk("px5_x", 64'(bus.grant_x), 64'd1);
        chk("px5_y", 64'(bus.grant_y), 64'd1);
        chk("px5_cr", 64'(bus.grant_cr), -64'sd90);
        chk("px5_ci", 64'(bus.grant_ci), 64'sd45);
      end
      if (e_grant != '0 && e_addr == 11) begin
        chk("last_x", 64'(bus.grant_x), 64'd3);
        chk("last_y", 64'(bus.grant_y), 64'd2);
        chk("last_cr", 64'(bus.grant_cr), -64'sd70);
        chk("last_ci", 64'(bus.grant_ci), 64'sd40);
      end
    end
    bus.complete = '0;
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    chk("drain_no_grant", 64'(bus.grant), 64'd0);
    for (int c = 0; c < 40 && !done; c++) begin
      bus.complete = (c % 2 == 0) ? 3'b111 : 3'b000;
      tick();
    end
    bus.complete = '0;
    chk("a_done", 64'(done), 64'd1);
    chk("a_time", 64'(solve_time), 64'(meas));
    bus.complete = 3'b111; tick(); bus.complete = '0; tick(); tick();
    chk("a_time_hold", 64'(solve_time), 64'(meas));

    // Frame B: three requesters, one grant per cycle in round-robin order.
    reset = 1'b1; tick(); reset = 1'b0;
    meas = 0; bus.req = 3'b111; start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < TOTAL; k++) begin
      tick();
      chk("rr_grant", 64'(bus.grant), 64'(3'b001 << (k % 3)));
    end
    tick();
    chk("rr_after", 64'(bus.grant), 64'd0);
    start = 1'b1; tick(); start = 1'b0;
    for (int p = 0; p < 4; p++) begin
      bus.complete = 3'b111; tick(); bus.complete = '0;
      chk("b_done_edge", 64'(done), 64'(p == 3));
      tick();
    end
    chk("b_busy", 64'(busy), 64'd0);
    chk("b_time", 64'(solve_time), 64'(meas));

    // Frame C: reset after 7 grants, then a clean restart.
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 20 && m_granted < 7; c++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("c_rst_grant", 64'(bus.grant), 64'd0);
    chk("c_rst_busy", 64'(busy), 64'd0);
    chk("c_rst_done", 64'(done), 64'd0);
    chk("c_rst_time", 64'(solve_time), 64'd0);
    bus.complete = 3'b111; tick(); bus.complete = '0;
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("c_x", 64'(bus.grant_x), 64'd0);
    chk("c_y", 64'(bus.grant_y), 64'd0);
    chk("c_cr", 64'(bus.grant_cr), -64'sd100);

    // Frame D: two's complement wrap of cr.
    reset = 1'b1; tick(); reset = 1'b0;
    min_x = 27'h3FF_FFFF; dx = 27'sd1;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    wrap_exp = 27'h400_0000;
    chk("wrap_cr", 64'(bus.grant_cr), 64'(wrap_exp));

    // Randomized frames.
    for (int f = 0; f < 3; f++) begin
      reset = 1'b1; tick(); reset = 1'b0;
      min_x = F'($urandom); min_y = F'($urandom); dx = F'($urandom); dy = F'($urandom);
      bus.req = '0;
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
        bus.req = N'($urandom);
        bus.complete = N'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) start = 1'b1;
        tick();
        start = 1'b0;
      end
      bus.req = '0; bus.complete = '0;
      chk("rand_done", 64'(done), 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/solver_work_dispatcher.md
Name: solver_work_dispatcher

Overview:
- Central scheduler sharing one frame of Mandelbrot pixel work between NUM_SOLVERS iteration engines.
- Engines request work over a req/grant handshake. The dispatcher arbitrates round-robin and hands out pixel coordinates with the matching complex c value.
- Tracks completions, asserts done when the frame is finished and reports the frame solve time.
- Sits between the HPS parameter PIOs (x_min, y_min, dx, dy, solver reset) and the solver array.

Parameters:
- NUM_SOLVERS, 29, number of requesting engines (1..64)
- WIDTH, 640, pixels per row
- HEIGHT, 480, rows per frame
- FRAC_W, 27, width of signed fixed-point coordinate values

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high; aborts any frame
- start  in  1  one-cycle pulse; latches parameters, begins frame
- min_x  in  FRAC_W  signed real coordinate of pixel (0,0)
- min_y  in  FRAC_W  signed imaginary coordinate of pixel (0,0)
- dx  in  FRAC_W  signed real step per column
- dy  in  FRAC_W  signed imaginary step per row
- req  in  NUM_SOLVERS  level request per engine, held until granted
- complete  in  NUM_SOLVERS  one-cycle pulse per engine when its pixel finishes; several bits may be set at once
- grant  out  NUM_SOLVERS  one-hot, one-cycle grant
- grant_x  out  10  column of granted pixel
- grant_y  out  9  row of granted pixel
- grant_addr  out  19  linear address y*WIDTH+x
- grant_cr  out  FRAC_W  min_x + x*dx
- grant_ci  out  FRAC_W  min_y + y*dy
- busy  out  1  frame in progress
- done  out  1  frame finished; held until next start or reset
- solve_time  out  32  cycles from start to done

Behaviour:
- Reset values:
  - grant=0; all grant_* data=0; busy=0; done=0; solve_time=0.
  - State IDLE; round-robin pointer=0; all counters=0.
- States:
  - IDLE --start--> DISPATCH
  - DISPATCH --last pixel granted--> DRAIN
  - DRAIN --completed==WIDTH*HEIGHT--> DONE
  - DONE --start--> DISPATCH
- On start (accepted only in IDLE or DONE):
  - latch min_x, min_y, dx, dy into internal registers
  - x=y=0; cr=min_x; ci=min_y; completed=0; solve_time=0; done=0; busy=1
- start in DISPATCH or DRAIN is ignored. Input parameter changes mid-frame have no effect.
- Arbitration (DISPATCH only):
  - Each cycle, choose the first set bit of eligible=req & ~grant, searching from pointer upward with wrap.
  - Masking the currently granted engine covers its one-cycle req drop latency.
  - Outputs are registered: a req sampled at cycle t yields grant and data valid at t+1, for exactly one cycle.
  - Pointer becomes winner+1 (mod NUM_SOLVERS).
  - No eligible request: grant=0, data registers hold, pointer unchanged.
- Throughput: at most one grant per cycle; sustained one per cycle with ≥2 requesters.
- Coordinate stepping after each grant:
  - x<WIDTH-1: x+1, cr+=dx.
  - Otherwise: x=0, cr=latched min_x, y+1, ci+=dy.
  - grant_addr increments by 1.
  - cr/ci add modulo 2^FRAC_W (two's complement wrap, no saturation); no multipliers.
- Last pixel: grant of (WIDTH-1, HEIGHT-1) moves to DRAIN. No further grants in DRAIN, DONE or IDLE; req is ignored there.
- Completion counting:
  - In DISPATCH and DRAIN, completed += popcount(complete), with outstanding = granted - completed.
  - Pulses beyond outstanding are dropped; completed never exceeds granted.
  - complete in IDLE or DONE is ignored.
- Same-cycle events:
  - A complete and a new req from the same engine in one cycle are both honoured.
  - A completion landing in the cycle the last grant issues is counted.
- solve_time:
  - increments every cycle while busy
  - freezes on the DRAIN->DONE transition, where done=1 and busy=0 are set together
  - saturates at 2^32-1
- Reset mid-frame: all outputs and state return to reset values next cycle. In-flight completions after reset are ignored.

Test Plan:
- Bench configuration: WIDTH=4, HEIGHT=3, NUM_SOLVERS=3; min_x=-100, min_y=50, dx=10, dy=-5.
- Single requester: start, req=3'b001 held -> 12 grants on alternating cycles. Pixel 5 shows x=1, y=1, addr=5, cr=-90, ci=45. Last grant is x=3, y=2, cr=-70, ci=40. grant stays 0 afterwards.
- Round-robin fairness: req=3'b111 held -> grant sequence 001,010,100,001,... one per cycle, 12 grants over 12 consecutive cycles, then DRAIN.
- Completion: pulse complete=3'b111 in one cycle four times -> done=1 the cycle after the 12th completion count, busy=0. solve_time equals the measured cycle count and holds.
- Over-completion and idle: extra complete pulses with outstanding=0 -> not counted; done asserts only after 12 real completions. complete in IDLE leaves state unchanged.
- start in DRAIN -> ignored. Reset asserted after 7 grants -> grant=0, busy=0, done=0, solve_time=0 next cycle. A new start restarts at x=0, y=0, cr=-100.
- Wrap: min_x=2^26-1, dx=1 -> second grant has grant_cr=-2^26, i.e. two's complement wrap.
